// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cpu_control_fsm
// Multicycle fetch/decode/execute sequencer for the 16-bit CPU datapath.
// Define CPU_FSM_BRANCH_EN to decode Bcond, Jcond and JAL.
// Revision : 1.0
// ============================================================================
module cpu_control_fsm #(
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
    input  logic [4:0]  flags,
    output logic        pc_enable,
    output logic [1:0]  pc_src,
    output logic        r_enable,
    output logic        ls_cntl,
    output logic        we,
    output logic [1:0]  wb_sel,
    output logic        ir_enable
);

    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_FETCH_WAIT = 4'd1,
        S_DECODE     = 4'd2,
        S_EXEC_R     = 4'd3,
        S_STORE      = 4'd4,
        S_LOAD_ADDR  = 4'd5,
        S_LOAD_WAIT  = 4'd6,
        S_LOAD_WB    = 4'd7,
        S_BR_TAKEN   = 4'd8,
        S_NEXT       = 4'd9,
        S_JAL        = 4'd10
    } state_e;

    localparam int               LAST_INT = (MEM_WAIT > 0) ? MEM_WAIT - 1 : 0;
    localparam logic [CNT_W-1:0] LAST_CNT = LAST_INT[CNT_W-1:0];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_last;

    logic [3:0] op;
    logic [3:0] ext;
    logic       is_load, is_store, is_bcond, is_jcond, is_jal;

    assign op       = instruction[15:12];
    assign ext      = instruction[7:4];
    assign is_load  = (op == 4'b0100) && (ext == 4'b0000);
    assign is_store = (op == 4'b0100) && (ext == 4'b0100);
    assign is_bcond = (op == 4'b1100);
    assign is_jcond = (op == 4'b0100) && (ext == 4'b1100);
    assign is_jal   = (op == 4'b0100) && (ext == 4'b1000);
    assign cnt_last = (cnt_q == LAST_CNT);

    logic unused_ok;
    assign unused_ok = ^{instruction[3:0], instruction[11:8], flags};

`ifdef CPU_FSM_BRANCH_EN
    logic [3:0] cc;
    logic       cond_true;
    logic       br_jump_q, br_jump_d;
    logic       f_c, f_l, f_f, f_z, f_n;

    assign cc  = instruction[11:8];
    assign f_c = flags[0];
    assign f_l = flags[1];
    assign f_f = flags[2];
    assign f_z = flags[3];
    assign f_n = flags[4];

    always_comb begin
        cond_true = 1'b0;
        case (cc)
            4'b0000: cond_true = f_z;
            4'b0001: cond_true = !f_z;
            4'b0010: cond_true = f_c;
            4'b0011: cond_true = !f_c;
            4'b0100: cond_true = f_l;
            4'b0101: cond_true = !f_l;
            4'b0110: cond_true = f_n;
            4'b0111: cond_true = !f_n;
            4'b1000: cond_true = f_f;
            4'b1001: cond_true = !f_f;
            4'b1010: cond_true = !f_l && !f_z;
            4'b1011: cond_true = f_l || f_z;
            4'b1100: cond_true = !f_n && !f_z;
            4'b1101: cond_true = f_n || f_z;
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Remembers whether the pending taken branch targets a register (Jcond)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_jump_q <= 1'b0;
        end else begin
            br_jump_q <= br_jump_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef CPU_FSM_BRANCH_EN
        br_jump_d = br_jump_q;
`endif
        case (state_q)
            S_FETCH: begin
                cnt_d   = '0;
                state_d = (MEM_WAIT > 0) ? S_FETCH_WAIT : S_DECODE;
            end
            S_FETCH_WAIT: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (is_load) begin
                    state_d = S_LOAD_ADDR;
                end else if (is_store) begin
                    state_d = S_STORE;
`ifdef CPU_FSM_BRANCH_EN
                end else if (is_bcond || is_jcond) begin
                    br_jump_d = is_jcond;
                    state_d   = cond_true ? S_BR_TAKEN : S_NEXT;
                end else if (is_jal) begin
                    state_d = S_JAL;
`else
                end else if (is_bcond || is_jcond || is_jal) begin
                    state_d = S_NEXT;
`endif
                end else begin
                    state_d = S_EXEC_R;
                end
            end
            S_LOAD_ADDR: begin
                cnt_d   = '0;
                state_d = (MEM_WAIT > 0) ? S_LOAD_WAIT : S_LOAD_WB;
            end
            S_LOAD_WAIT: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_LOAD_WB;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC_R, S_STORE, S_LOAD_WB, S_NEXT: begin
                state_d = S_FETCH;
            end
`ifdef CPU_FSM_BRANCH_EN
            S_BR_TAKEN, S_JAL: begin
                state_d = S_FETCH;
            end
`endif
            default: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore outputs; unknown encodings leave every enable low
    always_comb begin
        pc_enable = 1'b0;
        pc_src    = 2'b00;
        r_enable  = 1'b0;
        ls_cntl   = 1'b0;
        we        = 1'b0;
        wb_sel    = 2'b00;
        ir_enable = 1'b0;
        case (state_q)
            S_FETCH: begin
                ls_cntl   = 1'b1;
                ir_enable = (MEM_WAIT == 0);
            end
            S_FETCH_WAIT: begin
                ls_cntl   = 1'b1;
                ir_enable = cnt_last;
            end
            S_DECODE: begin
                ls_cntl = 1'b1;
            end
            S_EXEC_R: begin
                r_enable  = 1'b1;
                pc_enable = 1'b1;
                ls_cntl   = 1'b1;
            end
            S_STORE: begin
                we        = 1'b1;
                pc_enable = 1'b1;
            end
            S_LOAD_WB: begin
                r_enable  = 1'b1;
                wb_sel    = 2'b01;
                pc_enable = 1'b1;
            end
            S_NEXT: begin
                pc_enable = 1'b1;
                ls_cntl   = 1'b1;
            end
`ifdef CPU_FSM_BRANCH_EN
            S_BR_TAKEN: begin
                pc_enable = 1'b1;
                pc_src    = br_jump_q ? 2'b10 : 2'b01;
            end
            S_JAL: begin
                r_enable  = 1'b1;
                wb_sel    = 2'b10;
                pc_enable = 1'b1;
                pc_src    = 2'b10;
                ls_cntl   = 1'b1;
            end
`endif
            default: begin
                pc_enable = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Parametrised multicycle control unit for the 16-bit CPU datapath. It sequences fetch, decode and execute for R-type, load, store, conditional branch, conditional jump and jump-and-link instructions. Memory latency is configurable through wait states. The block drives the PC, register file, memory bus address mux, writeback mux and instruction register enables. It sits between the instruction register/flag register and the datapath control inputs.

## Interface
Parameters:
- MEM_WAIT, 1, extra cycles the memory needs before read data is valid (0..15).
- CNT_W, 4, width of the wait-state counter; must hold MEM_WAIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- instruction  in  16  instruction register output, valid from DECODE onward.
- flags  in  5  flag register: [0]=C, [1]=L, [2]=F, [3]=Z, [4]=N.
- pc_enable  out  1  PC update strobe.
- pc_src  out  2  next PC: 00 = PC+1, 01 = PC+sign-extended disp, 10 = register Rtarget.
- r_enable  out  1  register file write enable.
- ls_cntl  out  1  memory port A address: 1 = PC, 0 = register Raddr.
- we  out  1  memory write enable.
- wb_sel  out  2  writeback source: 00 = ALU, 01 = memory, 10 = PC+1.
- ir_enable  out  1  instruction register load.

## Operation
- Moore machine: all outputs decode from state and wait counter only.
- States: FETCH, FETCH_WAIT, DECODE, EXEC_R, STORE, LOAD_ADDR, LOAD_WAIT, LOAD_WB, BR_TAKEN, NEXT, JAL.
- Decode is done in DECODE on op = instruction[15:12] and ext = instruction[7:4]:
  - op 0100, ext 0000: LOAD.
  - op 0100, ext 0100: STORE.
  - op 1100: Bcond.
  - op 0100, ext 1100: Jcond.
  - op 0100, ext 1000: JAL.
  - All other encodings: EXEC_R.
- Condition code is instruction[11:8]:
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; HI 0100 L; LS 0101 !L; GT 0110 N; LE 0111 !N.
  - FS 1000 F; FC 1001 !F; LO 1010 !L&!Z; HS 1011 L|Z; LT 1100 !N&!Z; GE 1101 N|Z; UC 1110 always; 1111 never.
- Bcond or Jcond taken goes to BR_TAKEN. BR_TAKEN asserts pc_enable, with pc_src=01 for Bcond and 10 for Jcond (latched from DECODE). Not taken goes to NEXT.
- Transitions:
  - FETCH to FETCH_WAIT when MEM_WAIT>0, else to DECODE.
  - FETCH_WAIT holds until its count reaches MEM_WAIT-1.
  - LOAD_ADDR to LOAD_WAIT (or LOAD_WB if MEM_WAIT=0).
  - LOAD_WAIT counts like FETCH_WAIT, then goes to LOAD_WB.
  - EXEC_R, STORE, LOAD_WB, BR_TAKEN, NEXT and JAL all return to FETCH.
- Outputs per state (unlisted outputs are 0):
  - FETCH/FETCH_WAIT: ls_cntl=1. ir_enable=1 in the final fetch cycle only (FETCH when MEM_WAIT=0, else the last FETCH_WAIT cycle).
  - DECODE: ls_cntl=1.
  - EXEC_R: r_enable=1, pc_enable=1, wb_sel=00, ls_cntl=1.
  - STORE: we=1, ls_cntl=0, pc_enable=1.
  - LOAD_ADDR and LOAD_WAIT: ls_cntl=0.
  - LOAD_WB: ls_cntl=0, r_enable=1, wb_sel=01, pc_enable=1.
  - NEXT: pc_enable=1, pc_src=00, ls_cntl=1.
  - JAL: r_enable=1, wb_sel=10, pc_enable=1, pc_src=10, ls_cntl=1.
- No x values on any output in any state. Illegal state encodings recover to FETCH on the next edge with all enables 0.

## Timing
- Reset (rst=0) forces FETCH and counter=0 immediately, independent of clk.
- Outputs in reset: all 0 except ls_cntl=1; ir_enable=1 only if MEM_WAIT=0.
- Reset asserted mid-instruction aborts it. A store cut off by reset never asserts we after rst falls.
- Cycles per instruction, W = MEM_WAIT:
  - R-type, store, branch/jump (taken or not), JAL: 3+W.
  - Load: 4+2W.
- pc_enable is exactly one cycle per instruction, in the final cycle.
- we is at most one cycle per store.

## Configuration
- CPU_FSM_BRANCH_EN defined: Bcond, Jcond and JAL are decoded as described.
- CPU_FSM_BRANCH_EN undefined:
  - Those encodings go to NEXT, acting as a no-op with PC+1.
  - BR_TAKEN and JAL states are not generated; pc_src is tied to 00 and wb_sel[1] to 0.

## Test plan
- Reset: rst=0 mid-LOAD_WAIT, then release -> outputs at reset values, first FETCH begins on the next edge.
- MEM_WAIT=0, ADD 0x0512 -> pc_enable and r_enable high together in cycle 3 only, wb_sel=00.
- MEM_WAIT=2, LOAD 0x4102 -> ir_enable in cycle 3, LOAD_WB in cycle 8 with wb_sel=01, r_enable=1.
- STORE 0x4146 -> we=1 and ls_cntl=0 for exactly one cycle, r_enable never high.
- BEQ 0xC005: with flags Z=1 (5'b01000) -> pc_src=01 with pc_enable; with flags=0 -> pc_src=00.
- JAL 0x4E81 with macro defined -> wb_sel=10, pc_src=10, r_enable=1. Without macro -> pc_src=00, r_enable=0.
